adf4158_spi_rx: RTL and testbench
=================================

// Module: adf4158_spi_rx
// PURPOSE
//  Receive side of the ADF4158 3-wire serial config interface (sclk/data/le). Oversamples the
//  pins on a fast system clock, shifts 32-bit MSB-first words and decodes each word on the LE
//  rising edge into a 10-entry shadow register bank. Used as a synthesizable loopback checker
//  and as the device model in configuration-path benches.
// PARAMETERS
//  SYNC_STAGES  2   flops per pin synchronizer (sclk, data, le, ce); legal 2..4
//  WORD_BITS    32  bits per valid frame; fixed by the device protocol
// PORTS
//  clk        in   1   system clock; must be >= 4x sclk frequency
//  rst_n      in   1   synchronous, active-low reset
//  sclk       in   1   serial clock from the writer; data is sampled on its rising edge
//  data       in   1   serial data, MSB first
//  le         in   1   load enable: low while shifting; rising edge commits the word
//  ce         in   1   chip enable; low = powered down
//  word_valid out  1   1-cycle pulse: good frame committed
//  word_data  out  32  committed word; held until the next commit
//  word_idx   out  4   bank slot written (0..9); held until the next commit
//  frame_err  out  1   1-cycle pulse: LE rose with bit count != 32
//  loaded     out  10  sticky per-slot "written since reset/power-down" flags
//  ramp_en    out  1   bank[0][31] & loaded[0]
//  rd_idx     in   4   bank readback index
//  rd_data    out  32  bank[rd_idx], registered (1 clk latency); 0 if rd_idx > 9
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): bank, shift reg, bit_cnt, loaded, word_data, word_idx, rd_data
//   = 0; word_valid = frame_err = 0; sync flops = 0, except the le chain, which resets to 1.
//  Sync: each pin passes through SYNC_STAGES flops. Edges are found by comparing the last sync
//   stage with a 1-flop delayed copy. All references below use these synchronized signals.
//  States: PWRDN (ce_s=0), IDLE (le_s=1), SHIFT (le_s=0).
//   PWRDN: bank, loaded and bit_cnt held at 0; pins ignored; leaves to IDLE when ce_s=1.
//   IDLE -> SHIFT on le_s falling; bit_cnt cleared on entry.
//   SHIFT: on each sclk_s rising edge, sr <= {sr[30:0], data_s};
//    bit_cnt += 1, saturating at 63 (6-bit).
//   SHIFT -> IDLE on le_s rising. Commit is evaluated in that same cycle.
//  Commit with bit_cnt == 32: decode ctrl = sr[2:0].
//   ctrl 0..4 -> slot 0..4
//   ctrl 5 -> slot 5 + sr[23]
//   ctrl 6 -> slot 7 + sr[23]
//   ctrl 7 -> slot 9
//   Write bank[slot] <= sr; set loaded[slot]; word_data <= sr; word_idx <= slot.
//   word_valid pulses the following cycle, i.e. SYNC_STAGES+2 clks after le rises at the pin.
//  Commit with bit_cnt != 32 (including 0 and saturated): bank unchanged;
//   frame_err pulses with the same timing as word_valid.
//  Simultaneous sclk_s rising and le_s rising in one cycle: the sclk edge is discarded and the
//   commit uses sr/bit_cnt as they stood before the edge.
//  sclk edges while le_s=1: ignored; sr and bit_cnt are untouched.
//  ce_s falling in any state aborts the frame: no commit and no frame_err; bank and loaded
//   cleared the next clk.
//  Reset mid-frame: everything clears; the partial word is lost with no pulse.
//  Back-to-back frames: a new le_s fall one clk after a commit is accepted.
//  Readback: rd_data <= (rd_idx<=9) ? bank[rd_idx] : 0 every clk. A commit to the read slot is
//   visible on rd_data one clk after the bank write.
// TESTING
//  T1 reset, ce=1, send R7 0x00008A07 (ctrl 7) -> word_valid, word_idx=9, loaded=10'h200,
//     rd_idx=9 reads 0x00008A07.
//  T2 send 0x00A00005 (R5, bit23=1), then 0x00200005 (R5, bit23=0) -> slots 6 and 5 respectively
//     hold those words; loaded[6:5]=2'b11.
//  T3 send 31 bits then raise le -> frame_err pulse, no word_valid; bank and loaded unchanged.
//     Repeat with 33 bits -> same result.
//  T4 R0 0x80000000|(265<<15)|(15<<27) -> ramp_en=1; then same with bit31=0 -> ramp_en=0.
//     Check latency SYNC_STAGES+2 clks.
//  T5 drop ce mid-frame after 16 bits -> no pulses; loaded=0, rd_data=0 for all slots;
//     raise ce, a full frame commits normally.
//  T6 sclk and le rising in the same synchronized cycle after exactly 32 prior bits ->
//     commit of those 32 bits, no frame_err; also rd_idx=12 -> rd_data=0.

Source files
------------

// File: rtl/adf4158_spi_rx.sv
// ADF4158 3-wire config receiver: oversampled sclk/data/le/ce, 32-bit MSB-first
// shift, decode on LE rise into a 10-slot shadow bank with registered readback.
module adf4158_spi_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned WORD_BITS   = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sclk,
   input  logic        data,
   input  logic        le,
   input  logic        ce,
   output logic        word_valid,
   output logic [31:0] word_data,
   output logic [3:0]  word_idx,
   output logic        frame_err,
   output logic [9:0]  loaded,
   output logic        ramp_en,
   input  logic [3:0]  rd_idx,
   output logic [31:0] rd_data
);

   typedef enum logic [1:0] {PWRDN, IDLE, SHIFT} state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] sclk_q, data_q, le_q, ce_q;
   logic        sclk_d, le_d, ce_d;
   logic        sclk_s, data_s, le_s, ce_s;
   logic        sclk_rise, le_rise, le_fall;
   logic        shift_en, commit, clr_cnt, pwr_clr;
   logic [31:0] sr;
   logic [5:0]  bit_cnt;
   logic [3:0]  slot;
   logic        valid_pend, err_pend;
   logic [31:0] bank [10];

   assign sclk_s = sclk_q[SYNC_STAGES-1];
   assign data_s = data_q[SYNC_STAGES-1];
   assign le_s   = le_q[SYNC_STAGES-1];
   assign ce_s   = ce_q[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_d;
   assign le_rise   = le_s & ~le_d;
   assign le_fall   = ~le_s & le_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_q <= '0;
         data_q <= '0;
         le_q   <= '1;
         ce_q   <= '0;
         sclk_d <= 1'b0;
         le_d   <= 1'b1;
         ce_d   <= 1'b0;
      end else begin
         sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
         data_q <= {data_q[SYNC_STAGES-2:0], data};
         le_q   <= {le_q[SYNC_STAGES-2:0], le};
         ce_q   <= {ce_q[SYNC_STAGES-2:0], ce};
         sclk_d <= sclk_s;
         le_d   <= le_s;
         ce_d   <= ce_s;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= PWRDN;
      else        state <= state_next;
   end

   // An le rise wins over a coincident sclk rise, so the commit sees the pre-edge word.
   always_comb begin
      state_next = state;
      shift_en   = 1'b0;
      commit     = 1'b0;
      clr_cnt    = 1'b0;
      if (!ce_s) begin
         state_next = PWRDN;
      end else begin
         case (state)
            PWRDN: state_next = IDLE;
            IDLE: begin
               if (le_fall) begin
                  state_next = SHIFT;
                  clr_cnt    = 1'b1;
               end
            end
            SHIFT: begin
               if (le_rise) begin
                  state_next = IDLE;
                  commit     = 1'b1;
               end else if (sclk_rise) begin
                  shift_en = 1'b1;
               end
            end
            default: state_next = PWRDN;
         endcase
      end
   end

   assign pwr_clr = ~ce_s | (state == PWRDN);

   always_comb begin
      slot = 4'd9;
      case (sr[2:0])
         3'd5:    slot = 4'd5 + {3'b000, sr[23]};
         3'd6:    slot = 4'd7 + {3'b000, sr[23]};
         3'd7:    slot = 4'd9;
         default: slot = {1'b0, sr[2:0]};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr         <= '0;
         bit_cnt    <= '0;
         loaded     <= '0;
         word_data  <= '0;
         word_idx   <= '0;
         rd_data    <= '0;
         valid_pend <= 1'b0;
         err_pend   <= 1'b0;
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         for (int unsigned i = 0; i < 10; i++) bank[i] <= '0;
      end else begin
         valid_pend <= 1'b0;
         err_pend   <= 1'b0;
         word_valid <= valid_pend;
         frame_err  <= err_pend;
         if (pwr_clr) begin
            bit_cnt <= '0;
            loaded  <= '0;
            for (int unsigned i = 0; i < 10; i++) bank[i] <= '0;
         end else begin
            if (clr_cnt) bit_cnt <= '0;
            if (shift_en) begin
               sr <= {sr[30:0], data_s};
               if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
            end
            if (commit) begin
               if (bit_cnt == 6'(WORD_BITS)) begin
                  bank[slot]   <= sr;
                  loaded[slot] <= 1'b1;
                  word_data    <= sr;
                  word_idx     <= slot;
                  valid_pend   <= 1'b1;
               end else begin
                  err_pend <= 1'b1;
               end
            end
         end
         rd_data <= (rd_idx <= 4'd9) ? bank[rd_idx] : '0;
      end
   end

   assign ramp_en = bank[0][31] & loaded[0];

endmodule

// File: tb/tb_adf4158_spi_rx.sv
// Bench for adf4158_spi_rx: directed and random frames checked against a slot-bank
// model built from the decode rules, with latency, readback and power-down checks.
module tb_adf4158_spi_rx;

   localparam int SS = 2;

   logic        clk;
   logic        rst_n, sclk, data, le, ce;
   logic [3:0]  rd_idx;
   logic        word_valid, frame_err, ramp_en;
   logic [31:0] word_data, rd_data;
   logic [3:0]  word_idx;
   logic [9:0]  loaded;

   adf4158_spi_rx #(.SYNC_STAGES(SS), .WORD_BITS(32)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .data(data), .le(le), .ce(ce),
      .word_valid(word_valid), .word_data(word_data), .word_idx(word_idx),
      .frame_err(frame_err), .loaded(loaded), .ramp_en(ramp_en),
      .rd_idx(rd_idx), .rd_data(rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int nvalid = 0;
   int nerr   = 0;

   logic [31:0] m_bank [10];
   logic [9:0]  m_loaded;

   always @(negedge clk) begin
      if (word_valid) nvalid++;
      if (frame_err)  nerr++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int slot_of(input logic [31:0] w);
      int c;
      int b23;
      c   = int'(w % 8);
      b23 = int'((w / 32'h0080_0000) % 2);
      if (c < 5)  return c;
      if (c == 5) return 5 + b23;
      if (c == 6) return 7 + b23;
      return 9;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 10; i++) m_bank[i] = '0;
      m_loaded = '0;
   endtask

   task automatic clock_bits(input logic [63:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         data = bits[i % 64];
         repeat (2) @(negedge clk);
         sclk = 1'b1;
         repeat (3) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic read_slot(input string tag, input int s, input logic [31:0] exp);
      rd_idx = 4'(s);
      @(posedge clk);
      #1;
      chk(tag, rd_data, exp);
      @(negedge clk);
   endtask

   task automatic run_frame(input string tag, input logic [63:0] bits, input int n,
                            input bit with_sclk);
      int v0, e0, lat, s;
      bit good;
      logic [31:0] w;
      le = 1'b0;
      repeat (4) @(negedge clk);
      clock_bits(bits, n);
      v0  = nvalid;
      e0  = nerr;
      lat = -1;
      le  = 1'b1;
      if (with_sclk) begin
         data = ~data;
         sclk = 1'b1;
      end
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         if ((word_valid || frame_err) && lat < 0) lat = c;
      end
      @(negedge clk);
      sclk = 1'b0;
      @(negedge clk);
      good = (n == 32);
      w    = bits[31:0];
      s    = good ? slot_of(w) : int'($urandom_range(0, 9));
      if (good) begin
         m_bank[s]   = w;
         m_loaded[s] = 1'b1;
      end
      chk({tag, ".valid_cnt"}, nvalid - v0, good ? 1 : 0);
      chk({tag, ".err_cnt"}, nerr - e0, good ? 0 : 1);
      chk({tag, ".latency"}, lat, SS + 2);
      if (good) begin
         chk({tag, ".word_data"}, word_data, w);
         chk({tag, ".word_idx"}, {28'd0, word_idx}, s);
      end
      chk({tag, ".loaded"}, {22'd0, loaded}, {22'd0, m_loaded});
      chk({tag, ".ramp_en"}, {31'd0, ramp_en}, {31'd0, m_bank[0][31] & m_loaded[0]});
      read_slot({tag, ".rd_data"}, s, m_bank[s]);
   endtask

   initial begin
      logic [63:0] r;
      int n, v0, e0;
      sclk = 1'b0; data = 1'b0; le = 1'b1; ce = 1'b0; rd_idx = '0; rst_n = 1'b0;
      model_clear();
      repeat (4) @(negedge clk);
      chk("rst.word_valid", {31'd0, word_valid}, 0);
      chk("rst.frame_err", {31'd0, frame_err}, 0);
      chk("rst.loaded", {22'd0, loaded}, 0);
      chk("rst.word_data", word_data, 0);
      chk("rst.word_idx", {28'd0, word_idx}, 0);
      chk("rst.rd_data", rd_data, 0);
      chk("rst.ramp_en", {31'd0, ramp_en}, 0);
      rst_n = 1'b1;
      ce    = 1'b1;
      repeat (6) @(negedge clk);

      run_frame("t1", 64'h0000_8A07, 32, 1'b0);
      chk("t1.loaded_200", {22'd0, loaded}, 32'h200);

      run_frame("t2a", 64'h00A0_0005, 32, 1'b0);
      run_frame("t2b", 64'h0020_0005, 32, 1'b0);
      read_slot("t2.slot6", 6, 32'h00A0_0005);
      read_slot("t2.slot5", 5, 32'h0020_0005);

      run_frame("t3_31", {$urandom, $urandom}, 31, 1'b0);
      run_frame("t3_33", {$urandom, $urandom}, 33, 1'b0);
      run_frame("t3_0", 64'd0, 0, 1'b0);
      run_frame("t3_66", {$urandom, $urandom}, 66, 1'b0);

      run_frame("t4_on", 64'hF884_8000, 32, 1'b0);
      chk("t4.ramp_on", {31'd0, ramp_en}, 1);
      run_frame("t4_off", 64'h7884_8000, 32, 1'b0);
      chk("t4.ramp_off", {31'd0, ramp_en}, 0);

      for (int k = 0; k < 8; k++) begin
         r = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0, 1:    n = 32;
            2:       n = 31;
            default: n = int'($urandom_range(0, 40));
         endcase
         run_frame("rnd", r, n, 1'b0);
      end

      le = 1'b0;
      repeat (4) @(negedge clk);
      clock_bits({$urandom, $urandom}, 16);
      v0 = nvalid;
      e0 = nerr;
      ce = 1'b0;
      repeat (8) @(negedge clk);
      le = 1'b1;
      repeat (8) @(negedge clk);
      model_clear();
      chk("t5.no_valid", nvalid - v0, 0);
      chk("t5.no_err", nerr - e0, 0);
      chk("t5.loaded", {22'd0, loaded}, 0);
      chk("t5.ramp_en", {31'd0, ramp_en}, 0);
      for (int s = 0; s < 10; s++) read_slot("t5.rd_zero", s, 32'd0);
      ce = 1'b1;
      repeat (6) @(negedge clk);
      run_frame("t5_after", {32'd0, $urandom}, 32, 1'b0);

      run_frame("t6", {32'd0, $urandom}, 32, 1'b1);
      read_slot("t6.rd_oob", 12, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
